axi_lite_sram_responder: RTL and testbench

- AXI4-Lite-style memory responder. It answers the core's instruction-fetch and load/store requests from a behavioural word-organised SRAM array.
- Sits on the slave side of the IFU/LSU bus. It replaces the combinational fetch/RAM path with a valid/ready handshake and a programmable response latency.
- Serves one transaction at a time, either a read or a write.

---
 rtl/axi_lite_sram_responder_if.sv | 39 +++
 rtl/axi_lite_sram_responder.sv | 225 ++++++++++++++++++++++
 tb/tb_axi_lite_sram_responder.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_sram_responder_if.sv
// AXI4-Lite style bus between the IFU/LSU (master) and the SRAM responder (slave).
// Carries the AR/R read channels and the AW/W/B write channels.
interface axi_lite_sram_responder_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  // Read address / read data
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  arvalid;
  logic                  arready;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  // Write address / write data / write response
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_sram_responder.sv
// Single-outstanding AXI4-Lite responder backed by a word-organised SRAM array.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-low reset
//   bus  - slave side of the AR/R/AW/W/B bus (axi_lite_sram_responder_if.slave)
// Read data appears RD_LATENCY cycles after the AR handshake, the write response
// WR_LATENCY cycles after both AW and W have been captured. Writes win over reads.
module axi_lite_sram_responder #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           DEPTH_WORDS = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h8000_0000),
  parameter int unsigned           RD_LATENCY  = 1,
  parameter int unsigned           WR_LATENCY  = 1
) (
  input logic                      clk,
  input logic                      rst,
  axi_lite_sram_responder_if.slave bus
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
  localparam int unsigned IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int unsigned MAX_LAT    = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
  localparam int unsigned CNT_W      = $clog2(MAX_LAT + 1);

  localparam logic [1:0]            RESP_OKAY   = 2'b00;
  localparam logic [1:0]            RESP_DECERR = 2'b11;
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A     = ADDR_WIDTH'(DEPTH_WORDS);

  typedef enum logic [2:0] {
    IDLE, RD_WAIT, RD_RESP, WR_COLLECT, WR_WAIT, WR_RESP
  } state_t;

  // The lower-bound test keeps wrapped (below-base) addresses from aliasing into range.
  function automatic logic addr_in_range(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return (a >= BASE_ADDR) && ((off >> 2) < DEPTH_A);
  endfunction

  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_WIDTH-1:0] a);
    logic [ADDR_WIDTH-1:0] off;
    off = a - BASE_ADDR;
    return IDX_W'(off >> 2);
  endfunction

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int i = 0; i < int'(STRB_WIDTH); i++) begin
      if (strb[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  state_t                 state;
  logic [CNT_W-1:0]       cnt;
  logic                   aw_cap;
  logic                   w_cap;
  logic [ADDR_WIDTH-1:0]  aw_addr;
  logic [DATA_WIDTH-1:0]  w_data;
  logic [STRB_WIDTH-1:0]  w_strb;
  logic [IDX_W-1:0]       rd_idx;
  logic                   rd_err;
  logic [DATA_WIDTH-1:0]  rdata_q;
  logic [1:0]             rresp_q;
  logic [1:0]             bresp_q;
  logic [DATA_WIDTH-1:0]  mem [DEPTH_WORDS];

  logic                   arready_c;
  logic                   awready_c;
  logic                   wready_c;
  logic                   ar_hs_c;
  logic                   aw_hs_c;
  logic                   w_hs_c;
  logic                   aw_now_c;
  logic                   w_now_c;
  logic                   collecting_c;
  logic                   accept_c;
  logic                   wr_fire_c;
  logic                   wr_ok_c;
  logic                   commit_c;
  logic                   ar_ok_c;
  logic [IDX_W-1:0]       ar_idx_c;
  logic [IDX_W-1:0]       wr_idx_c;
  logic [ADDR_WIDTH-1:0]  eff_addr_c;
  logic [DATA_WIDTH-1:0]  eff_data_c;
  logic [STRB_WIDTH-1:0]  eff_strb_c;

  // Ready generation from state and captured flags, forced low in reset.
  always_comb begin
    arready_c = 1'b0;
    awready_c = 1'b0;
    wready_c  = 1'b0;
    if (rst) begin
      case (state)
        IDLE: begin
          awready_c = ~aw_cap;
          wready_c  = ~w_cap;
          arready_c = ~bus.awvalid & ~bus.wvalid & ~aw_cap & ~w_cap;
        end
        WR_COLLECT: begin
          awready_c = ~aw_cap;
          wready_c  = ~w_cap;
        end
        default: ;
      endcase
    end
  end

  // Write-side view: a channel handshaking this cycle overrides its capture register.
  always_comb begin
    collecting_c = (state == IDLE) || (state == WR_COLLECT);
    ar_hs_c      = bus.arvalid & arready_c;
    aw_hs_c      = bus.awvalid & awready_c;
    w_hs_c       = bus.wvalid & wready_c;
    aw_now_c     = aw_cap | aw_hs_c;
    w_now_c      = w_cap | w_hs_c;
    eff_addr_c   = aw_hs_c ? bus.awaddr : aw_addr;
    eff_data_c   = w_hs_c ? bus.wdata : w_data;
    eff_strb_c   = w_hs_c ? bus.wstrb : w_strb;
    accept_c     = collecting_c & aw_now_c & w_now_c;
    wr_fire_c    = (accept_c && (WR_LATENCY == 1)) ||
                   ((state == WR_WAIT) && (cnt == CNT_W'(1)));
    wr_ok_c      = addr_in_range(eff_addr_c);
    wr_idx_c     = addr_index(eff_addr_c);
    commit_c     = rst & wr_fire_c & wr_ok_c;
    ar_ok_c      = addr_in_range(bus.araddr);
    ar_idx_c     = addr_index(bus.araddr);
  end

  // Array write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (commit_c) mem[wr_idx_c] <= merge_bytes(mem[wr_idx_c], eff_data_c, eff_strb_c);
  end

  // Transaction FSM.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      aw_cap  <= 1'b0;
      w_cap   <= 1'b0;
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
      bresp_q <= RESP_OKAY;
    end else begin
      case (state)
        IDLE, WR_COLLECT: begin
          if (aw_hs_c) begin
            aw_addr <= bus.awaddr;
            aw_cap  <= 1'b1;
          end
          if (w_hs_c) begin
            w_data <= bus.wdata;
            w_strb <= bus.wstrb;
            w_cap  <= 1'b1;
          end
          if (accept_c) begin
            if (WR_LATENCY == 1) begin
              bresp_q <= wr_ok_c ? RESP_OKAY : RESP_DECERR;
              state   <= WR_RESP;
            end else begin
              cnt   <= CNT_W'(WR_LATENCY - 1);
              state <= WR_WAIT;
            end
          end else if (aw_now_c || w_now_c) begin
            state <= WR_COLLECT;
          end else if (ar_hs_c) begin
            rd_idx <= ar_idx_c;
            rd_err <= ~ar_ok_c;
            if (RD_LATENCY == 1) begin
              rdata_q <= ar_ok_c ? mem[ar_idx_c] : '0;
              rresp_q <= ar_ok_c ? RESP_OKAY : RESP_DECERR;
              state   <= RD_RESP;
            end else begin
              cnt   <= CNT_W'(RD_LATENCY - 1);
              state <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            rdata_q <= rd_err ? '0 : mem[rd_idx];
            rresp_q <= rd_err ? RESP_DECERR : RESP_OKAY;
            state   <= RD_RESP;
          end
          cnt <= cnt - CNT_W'(1);
        end
        RD_RESP: begin
          if (bus.rready) state <= IDLE;
        end
        WR_WAIT: begin
          if (cnt == CNT_W'(1)) begin
            bresp_q <= wr_ok_c ? RESP_OKAY : RESP_DECERR;
            state   <= WR_RESP;
          end
          cnt <= cnt - CNT_W'(1);
        end
        WR_RESP: begin
          if (bus.bready) begin
            aw_cap <= 1'b0;
            w_cap  <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.arready = arready_c;
  assign bus.awready = awready_c;
  assign bus.wready  = wready_c;
  assign bus.rvalid  = rst & (state == RD_RESP);
  assign bus.bvalid  = rst & (state == WR_RESP);
  assign bus.rdata   = rdata_q;
  assign bus.rresp   = rresp_q;
  assign bus.bresp   = bresp_q;

endmodule

// File: tb/tb_axi_lite_sram_responder.sv
// Scoreboard bench: two responders (RD/WR latency 1/1 and 3/2) share one stimulus
// driver; sel routes valids/readies to one of them and muxes its outputs back.
module tb_axi_lite_sram_responder;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic [31:0] araddr;
  logic        arvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        bready;

  logic        m_arready, m_awready, m_wready, m_rvalid, m_bvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp, m_bresp;

  int          n_tests = 0;
  int          n_fail  = 0;
  rexp_t       rexp_q[$];
  logic [1:0]  bexp_q[$];

  always #5 clk = ~clk;

  axi_lite_sram_responder_if bus1 ();
  axi_lite_sram_responder_if bus3 ();

  assign bus1.araddr  = araddr;
  assign bus1.arvalid = arvalid & ~sel;
  assign bus1.rready  = rready & ~sel;
  assign bus1.awaddr  = awaddr;
  assign bus1.awvalid = awvalid & ~sel;
  assign bus1.wdata   = wdata;
  assign bus1.wstrb   = wstrb;
  assign bus1.wvalid  = wvalid & ~sel;
  assign bus1.bready  = bready & ~sel;

  assign bus3.araddr  = araddr;
  assign bus3.arvalid = arvalid & sel;
  assign bus3.rready  = rready & sel;
  assign bus3.awaddr  = awaddr;
  assign bus3.awvalid = awvalid & sel;
  assign bus3.wdata   = wdata;
  assign bus3.wstrb   = wstrb;
  assign bus3.wvalid  = wvalid & sel;
  assign bus3.bready  = bready & sel;

  assign m_arready = sel ? bus3.arready : bus1.arready;
  assign m_awready = sel ? bus3.awready : bus1.awready;
  assign m_wready  = sel ? bus3.wready  : bus1.wready;
  assign m_rvalid  = sel ? bus3.rvalid  : bus1.rvalid;
  assign m_bvalid  = sel ? bus3.bvalid  : bus1.bvalid;
  assign m_rdata   = sel ? bus3.rdata   : bus1.rdata;
  assign m_rresp   = sel ? bus3.rresp   : bus1.rresp;
  assign m_bresp   = sel ? bus3.bresp   : bus1.bresp;

  axi_lite_sram_responder #(.RD_LATENCY(1), .WR_LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  axi_lite_sram_responder #(.RD_LATENCY(3), .WR_LATENCY(2)) dut3 (
    .clk(clk), .rst(rst), .bus(bus3)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: compare every presented response against the head of its queue.
  always @(negedge clk) begin
    if (rst) begin
      if (m_rvalid) begin
        if (rexp_q.size() == 0) begin
          check("r_unexpected", 32'(m_rvalid), 32'(0));
        end else begin
          check("rdata", m_rdata, rexp_q[0].data);
          check("rresp", 32'(m_rresp), 32'(rexp_q[0].resp));
          if (rready) void'(rexp_q.pop_front());
        end
      end
      if (m_bvalid) begin
        if (bexp_q.size() == 0) begin
          check("b_unexpected", 32'(m_bvalid), 32'(0));
        end else begin
          check("bresp", 32'(m_bresp), 32'(bexp_q[0]));
          if (bready) void'(bexp_q.pop_front());
        end
      end
    end
  end

  // Waits (bounded) until the requested ready is seen at a negedge; the next posedge handshakes.
  task automatic wait_ready(input int ch, input string name);
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      case (ch)
        0: if (m_arready) return;
        1: if (m_awready) return;
        2: if (m_wready) return;
        default: if (m_awready && m_wready) return;
      endcase
    end
    check(name, 32'(0), 32'(1));
  endtask

  // Tasks start and end at posedge+1.
  task automatic do_read(input logic [31:0] addr, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int exp_lat, input int hold);
    rexp_t e;
    int    n;
    e.data = exp_data;
    e.resp = exp_resp;
    rexp_q.push_back(e);
    araddr  = addr;
    arvalid = 1'b1;
    rready  = 1'b0;
    wait_ready(0, "ar_timeout");
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 1;
    while (!m_rvalid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("r_latency", 32'(n), 32'(exp_lat));
    repeat (hold) begin
      check("arready_busy", 32'(m_arready), 32'(0));
      check("rvalid_held", 32'(m_rvalid), 32'(1));
      @(posedge clk); #1;
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    check("r_done", 32'(m_rvalid), 32'(0));
  endtask

  // mode 0: AW and W together; 1: W first; 2: AW first (gap cycles between handshakes).
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int mode, input int gap, input logic [1:0] exp_resp,
                          input int exp_lat);
    int n;
    bexp_q.push_back(exp_resp);
    awaddr = addr;
    wdata  = data;
    wstrb  = strb;
    bready = 1'b0;
    if (mode == 0) begin
      awvalid = 1'b1;
      wvalid  = 1'b1;
      wait_ready(3, "aw_w_timeout");
      @(posedge clk); #1;
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end else begin
      if (mode == 1) wvalid = 1'b1; else awvalid = 1'b1;
      wait_ready((mode == 1) ? 2 : 1, "first_ch_timeout");
      @(posedge clk); #1;
      awvalid = 1'b0;
      wvalid  = 1'b0;
      check("collect_awready", 32'(m_awready), (mode == 1) ? 32'(1) : 32'(0));
      check("collect_wready", 32'(m_wready), (mode == 1) ? 32'(0) : 32'(1));
      repeat (gap - 1) begin
        @(posedge clk); #1;
      end
      if (mode == 1) awvalid = 1'b1; else wvalid = 1'b1;
      wait_ready((mode == 1) ? 1 : 2, "second_ch_timeout");
      @(posedge clk); #1;
      awvalid = 1'b0;
      wvalid  = 1'b0;
    end
    n = 1;
    while (!m_bvalid && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("b_latency", 32'(n), 32'(exp_lat));
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("b_done", 32'(m_bvalid), 32'(0));
  endtask

  initial begin
    rexp_t e;
    rst = 1'b0; sel = 1'b0;
    araddr = 32'h9000_0000; arvalid = 1'b1; rready = 1'b0;
    awaddr = '0; awvalid = 1'b0; wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;

    // Reset holds every ready/valid low even with arvalid asserted.
    repeat (3) begin
      @(negedge clk);
      check("rst_arready", 32'(m_arready), 32'(0));
      check("rst_rvalid", 32'(m_rvalid), 32'(0));
      check("rst_bvalid", 32'(m_bvalid), 32'(0));
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("post_rst_arready", 32'(m_arready), 32'(1));
    do_read(32'h9000_0000, 32'h0, 2'b11, 1, 0);

    // Full write then read back.
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, 2'b00, 1);
    do_read(32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 1, 0);

    // W two cycles before AW, strobes 0101.
    do_write(32'h8000_0010, 32'h1122_3344, 4'b0101, 1, 2, 2'b00, 1);
    do_read(32'h8000_0010, 32'hDE22_BE44, 2'b00, 1, 0);

    // Empty strobe leaves the word alone.
    do_write(32'h8000_0010, 32'hFFFF_FFFF, 4'h0, 0, 0, 2'b00, 1);
    do_read(32'h8000_0010, 32'hDE22_BE44, 2'b00, 1, 0);

    // Decode errors: below base, one past the end (would alias word 0), last word.
    do_read(32'h7FFF_FFFC, 32'h0, 2'b11, 1, 0);
    do_write(32'h8000_0000, 32'h1234_5678, 4'hF, 0, 0, 2'b00, 1);
    do_write(32'h8000_1000, 32'hAAAA_AAAA, 4'hF, 0, 0, 2'b11, 1);
    do_read(32'h8000_0000, 32'h1234_5678, 2'b00, 1, 0);
    do_read(32'h8000_1000, 32'h0, 2'b11, 1, 0);
    do_write(32'h8000_0FFC, 32'h0BAD_F00D, 4'hF, 0, 0, 2'b00, 1);
    do_read(32'h8000_0FFC, 32'h0BAD_F00D, 2'b00, 1, 2);

    // Simultaneous read and write: the write goes first.
    bexp_q.push_back(2'b00);
    e.data = 32'h55AA_55AA;
    e.resp = 2'b00;
    rexp_q.push_back(e);
    awaddr = 32'h8000_0020; wdata = 32'h55AA_55AA; wstrb = 4'hF;
    araddr = 32'h8000_0020;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
    @(negedge clk);
    check("sim_arready", 32'(m_arready), 32'(0));
    check("sim_awready", 32'(m_awready), 32'(1));
    check("sim_wready", 32'(m_wready), 32'(1));
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    check("sim_bvalid", 32'(m_bvalid), 32'(1));
    check("sim_ar_blocked", 32'(m_arready), 32'(0));
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    check("sim_ar_after_b", 32'(m_arready), 32'(1));
    wait_ready(0, "sim_ar_timeout");
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("sim_rvalid", 32'(m_rvalid), 32'(1));
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;

    // Long-latency responder: write latency 2, read latency 3 with backpressure.
    sel = 1'b1;
    #1;
    do_write(32'h8000_0000, 32'hCAFE_F00D, 4'hF, 0, 0, 2'b00, 2);
    do_read(32'h8000_0000, 32'hCAFE_F00D, 2'b00, 3, 4);
    do_write(32'h8000_0004, 32'h0102_0304, 4'hF, 2, 1, 2'b00, 2);
    do_read(32'h8000_0004, 32'h0102_0304, 2'b00, 3, 0);

    // Reset during RD_WAIT drops the read silently.
    araddr = 32'h8000_0000; arvalid = 1'b1;
    wait_ready(0, "mr_ar_timeout");
    @(posedge clk); #1;
    arvalid = 1'b0;
    rst = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      check("mr_rvalid", 32'(m_rvalid), 32'(0));
      check("mr_idle", 32'(m_arready), 32'(1));
    end

    check("r_queue_empty", 32'(rexp_q.size()), 32'(0));
    check("b_queue_empty", 32'(bexp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
